// File: rtl/sar_ctrl_nb_if.sv
// Handshake bundle between the SAR controller, the comparator and the CDAC drivers.
// master = controller side, slave = analog front end.
interface sar_ctrl_nb_if #(
  parameter int NBIT = 10
);
  logic            EN;
  logic            RDY;
  logic            CMP_P;
  logic            CMP_N;
  logic            CKS;
  logic            CKSB;
  logic            CMP_EN;
  logic [0:NBIT-1] CF;
  logic [0:NBIT-1] SWP;
  logic [0:NBIT-1] SWN;
  logic [0:NBIT-1] DATA;
  logic            CKO;
  logic            ERR;

  modport master (
    input  EN, RDY, CMP_P, CMP_N,
    output CKS, CKSB, CMP_EN, CF, SWP, SWN,
    output DATA, CKO, ERR
  );

  modport slave (
    output EN, RDY, CMP_P, CMP_N,
    input  CKS, CKSB, CMP_EN, CF, SWP, SWN,
    input  DATA, CKO, ERR
  );
endinterface

// File: rtl/sar_ctrl_nb.sv
// N-bit SAR ADC controller with comparator strobe/ready handshake per bit.
// Define SAR_CMP_TMO_EN to force-decide a bit after TMO_CYC cycles without RDY.
module sar_ctrl_nb #(
  parameter int NBIT       = 10,
  parameter int SAMPLE_CYC = 2,
  parameter int TMO_CYC    = 8
) (
  input logic           CLK,
  input logic           RST,
  sar_ctrl_nb_if.master bus
);
  localparam int KW = $clog2(NBIT);
  localparam int CW = $clog2(SAMPLE_CYC + 1);

  generate
    if (NBIT < 4 || NBIT > 16) begin : g_bad_nbit
      $error("NBIT must be 4..16");
    end
    if (SAMPLE_CYC < 1) begin : g_bad_sample
      $error("SAMPLE_CYC must be >= 1");
    end
    if (TMO_CYC < 2) begin : g_bad_tmo
      $error("TMO_CYC must be >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE, SAMPLE, BRST, BEVAL, DONE
  } state_t;

  typedef logic [0:NBIT-1] vec_t;

  state_t          st, st_n;
  logic [KW-1:0]   k, k_n;
  logic [CW-1:0]   sc, sc_n;
  logic            ef, ef_n;
  logic            cks, cks_n;
  logic            cksb;
  logic            cen, cen_n;
  logic            cko, cko_n;
  logic            err, err_n;
  vec_t            cf, cf_n;
  vec_t            swp, swp_n;
  vec_t            swn, swn_n;
  vec_t            data, data_n;
  logic            start, hit, d, bad;

`ifdef SAR_CMP_TMO_EN
  localparam int TW = $clog2(TMO_CYC);
  logic [TW-1:0]   tc, tc_n;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      st   <= IDLE;
      k    <= '0;
      sc   <= '0;
      ef   <= 1'b0;
      cks  <= 1'b0;
      cksb <= 1'b1;
      cen  <= 1'b0;
      cko  <= 1'b0;
      err  <= 1'b0;
      cf   <= '0;
      swp  <= '0;
      swn  <= '0;
      data <= '0;
`ifdef SAR_CMP_TMO_EN
      tc   <= '0;
`endif
    end else begin
      st   <= st_n;
      k    <= k_n;
      sc   <= sc_n;
      ef   <= ef_n;
      cks  <= cks_n;
      cksb <= ~cks_n;
      cen  <= cen_n;
      cko  <= cko_n;
      err  <= err_n;
      cf   <= cf_n;
      swp  <= swp_n;
      swn  <= swn_n;
      data <= data_n;
`ifdef SAR_CMP_TMO_EN
      tc   <= tc_n;
`endif
    end
  end

  always_comb begin
    st_n   = st;
    k_n    = k;
    sc_n   = sc;
    ef_n   = ef;
    cks_n  = cks;
    cen_n  = cen;
    cko_n  = 1'b0;
    err_n  = err;
    cf_n   = cf;
    swp_n  = swp;
    swn_n  = swn;
    data_n = data;
    start  = 1'b0;
    hit    = 1'b0;
    d      = 1'b0;
    bad    = 1'b0;
`ifdef SAR_CMP_TMO_EN
    tc_n   = tc;
`endif
    unique case (st)
      IDLE: start = bus.EN;
      SAMPLE: begin
        if (sc == CW'(SAMPLE_CYC - 1)) begin
          cks_n = 1'b0;
          k_n   = '0;
          st_n  = BRST;
        end else begin
          sc_n = sc + CW'(1);
        end
      end
      BRST: begin
        cen_n = 1'b1;
        st_n  = BEVAL;
`ifdef SAR_CMP_TMO_EN
        tc_n  = '0;
`endif
      end
      BEVAL: begin
        hit = bus.RDY;
        d   = bus.CMP_P & ~bus.CMP_N;
        bad = bus.CMP_P ~^ bus.CMP_N;
`ifdef SAR_CMP_TMO_EN
        if (!bus.RDY) begin
          if (tc == TW'(TMO_CYC - 1)) begin
            hit = 1'b1;
            d   = 1'b0;
            bad = 1'b1;
          end else begin
            tc_n = tc + TW'(1);
          end
        end
`endif
        if (hit) begin
          swp_n[k] = d;
          swn_n[k] = ~d;
          cf_n[k]  = 1'b1;
          cen_n    = 1'b0;
          ef_n     = ef | bad;
          if (k == KW'(NBIT - 1)) begin
            st_n   = DONE;
            data_n = swp_n;
            err_n  = ef_n;
            cko_n  = 1'b1;
          end else begin
            k_n  = k + KW'(1);
            st_n = BRST;
          end
        end
      end
      DONE: begin
        start = bus.EN;
        if (!bus.EN) st_n = IDLE;
      end
      default: st_n = IDLE;
    endcase
    // Shared entry into SAMPLE from IDLE or back-to-back from DONE
    if (start) begin
      st_n  = SAMPLE;
      cks_n = 1'b1;
      sc_n  = '0;
      cf_n  = '0;
      swp_n = '0;
      swn_n = '0;
      ef_n  = 1'b0;
    end
  end

  assign bus.CKS    = cks;
  assign bus.CKSB   = cksb;
  assign bus.CMP_EN = cen;
  assign bus.CF     = cf;
  assign bus.SWP    = swp;
  assign bus.SWN    = swn;
  assign bus.DATA   = data;
  assign bus.CKO    = cko;
  assign bus.ERR    = err;
endmodule

// File: tb/tb_sar_ctrl_nb.sv
// Bench for sar_ctrl_nb: comparator responder, conversion-level model
// and directed scenarios with literal expectations.
module tb_sar_ctrl_nb;
  localparam int N = 10;
  localparam int S = 2;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sar_ctrl_nb_if #(.NBIT(N)) bus ();

  sar_ctrl_nb #(
    .NBIT(N),
    .SAMPLE_CYC(S),
    .TMO_CYC(T)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  int nchk = 0;
  int nerr = 0;

  logic [0:N-1] code = '0;
  logic [0:N-1] badm = '0;
  int           dly = 0;
  bit           hold = 1'b0;
  bit           withhold = 1'b0;

  logic [0:N-1] exp_data = '0;
  logic         exp_err = 1'b0;
  int           exp_per = 0;
  bit           per_chk = 1'b0;

  int   bidx = 0;
  int   hcnt = 0;
  bit   acc_prev = 1'b0;
  logic rdy_v;

  int   cko_cnt = 0;
  int   gap = 0;
  int   last_gap = 0;
  bit   have_prev = 1'b0;
  int   cks_run = 0;
  bit   rst_prev = 1'b1;
  logic [0:N-1] pdata;
  logic         perr;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Conversion-level model: data is the code with invalid bits forced to 0
  task automatic set_exp();
    exp_data = code & ~badm;
    exp_err  = |badm;
    exp_per  = S + N * (2 + dly) + 1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cko(input int maxc);
    int c0;
    bit seen;
    c0 = cko_cnt;
    seen = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      tick(1);
      if (cko_cnt != c0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      nchk++;
      nerr++;
      $display("FAIL cko_timeout: no CKO within %0d cycles at %0t", maxc, $time);
    end
  endtask

  task automatic pulse_en();
    bus.EN = 1'b1;
    tick(1);
    bus.EN = 1'b0;
  endtask

  // Comparator responder
  initial begin
    bus.RDY   = 1'b0;
    bus.CMP_P = 1'b0;
    bus.CMP_N = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bidx     = 0;
        hcnt     = 0;
        acc_prev = 1'b0;
        bus.RDY  = 1'b0;
      end else begin
        if (acc_prev) bidx = (bidx == N - 1) ? 0 : bidx + 1;
        hcnt  = bus.CMP_EN ? hcnt + 1 : 0;
        rdy_v = hold || (bus.CMP_EN && !(withhold && bidx == 0) && hcnt > dly);
        bus.RDY = rdy_v;
        if (badm[bidx]) begin
          bus.CMP_P = 1'b1;
          bus.CMP_N = 1'b1;
        end else begin
          bus.CMP_P = code[bidx];
          bus.CMP_N = ~code[bidx];
        end
`ifdef SAR_CMP_TMO_EN
        acc_prev = bus.CMP_EN && (rdy_v || hcnt == T);
`else
        acc_prev = bus.CMP_EN && rdy_v;
`endif
      end
    end
  end

  // Compare process
  initial begin
    logic         cs;
    logic         csb_req;
    logic [0:N-1] nd;
    forever begin
      @(negedge clk);
      if (!rst && !rst_prev) begin
        cs      = bus.CKS;
        csb_req = ~cs;
        check("cksb", {31'b0, bus.CKSB}, {31'b0, csb_req});
        gap++;
        if (bus.CKO) begin
          cko_cnt++;
          nd = ~exp_data;
          check("data", 32'(bus.DATA), 32'(exp_data));
          check("err", {31'b0, bus.ERR}, {31'b0, exp_err});
          check("swp", 32'(bus.SWP), 32'(exp_data));
          check("swn", 32'(bus.SWN), 32'(nd));
          check("cf", 32'(bus.CF), 32'(N'('1)));
          if (per_chk && have_prev) check("period", gap, exp_per);
          last_gap  = gap;
          gap       = 0;
          have_prev = per_chk;
        end else begin
          check("data_hold", 32'(bus.DATA), 32'(pdata));
          check("err_hold", {31'b0, bus.ERR}, {31'b0, perr});
        end
        if (bus.CKS) begin
          cks_run++;
          check("cmp_en_in_sample", {31'b0, bus.CMP_EN}, 32'd0);
        end else if (cks_run != 0) begin
          check("cks_len", cks_run, S);
          cks_run = 0;
        end
      end else begin
        have_prev = 1'b0;
        cks_run   = 0;
      end
      pdata    = bus.DATA;
      perr     = bus.ERR;
      rst_prev = rst;
    end
  end

  initial begin
    int c0;
    bit found;
    bus.EN = 1'b0;
    rst    = 1'b1;
    tick(2);
    rst = 1'b0;

    // Idle after reset
    tick(50);
    check("idle_cko_count", cko_cnt, 0);
    check("idle_cksb", {31'b0, bus.CKSB}, 32'd1);
    check("idle_cks", {31'b0, bus.CKS}, 32'd0);
    check("idle_data", 32'(bus.DATA), 32'd0);
    check("idle_cf", 32'(bus.CF), 32'd0);

    // Single conversion, RDY one cycle after CMP_EN rises
    code = 10'b1011001110;
    badm = '0;
    dly  = 1;
    set_exp();
    pulse_en();
    wait_cko(300);
    tick(40);
    check("single_cko_count", cko_cnt, 1);
    check("single_data", 32'(bus.DATA), 32'h2CE);
    check("single_swn", 32'(bus.SWN), 32'h131);
    check("single_err", {31'b0, bus.ERR}, 32'd0);
    check("single_cf", 32'(bus.CF), 32'h3FF);

    // Continuous mode, RDY held high
    dly  = 0;
    hold = 1'b1;
    code = 10'b0110100101;
    set_exp();
    per_chk = 1'b1;
    bus.EN = 1'b1;
    repeat (4) wait_cko(100);
    check("period_literal", last_gap, 23);
    bus.EN = 1'b0;
    c0 = cko_cnt;
    wait_cko(100);
    tick(60);
    check("en_off_drains_one", cko_cnt, c0 + 1);
    per_chk = 1'b0;
    hold = 1'b0;

    // Invalid decision on bit 3, then a clean conversion
    code = 10'b1011001110;
    badm = '0;
    badm[3] = 1'b1;
    set_exp();
    pulse_en();
    wait_cko(200);
    tick(3);
    check("bad_data", 32'(bus.DATA), 32'h28E);
    check("bad_err", {31'b0, bus.ERR}, 32'd1);
    badm = '0;
    set_exp();
    pulse_en();
    wait_cko(200);
    tick(3);
    check("clean_err", {31'b0, bus.ERR}, 32'd0);
    check("clean_data", 32'(bus.DATA), 32'h2CE);

    // Reset at bit 5
    code = 10'b0011110000;
    set_exp();
    pulse_en();
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bidx == 5 && bus.CMP_EN) begin
        found = 1'b1;
        break;
      end
      tick(1);
    end
    if (!found) begin
      nchk++;
      nerr++;
      $display("FAIL bit5_timeout: bit 5 not reached at %0t", $time);
    end
    c0  = cko_cnt;
    rst = 1'b1;
    tick(1);
    check("rst_cks", {31'b0, bus.CKS}, 32'd0);
    check("rst_cksb", {31'b0, bus.CKSB}, 32'd1);
    check("rst_cmp_en", {31'b0, bus.CMP_EN}, 32'd0);
    check("rst_cko", {31'b0, bus.CKO}, 32'd0);
    check("rst_err", {31'b0, bus.ERR}, 32'd0);
    check("rst_cf", 32'(bus.CF), 32'd0);
    check("rst_swp", 32'(bus.SWP), 32'd0);
    check("rst_swn", 32'(bus.SWN), 32'd0);
    check("rst_data", 32'(bus.DATA), 32'd0);
    rst = 1'b0;
    tick(40);
    check("rst_no_cko", cko_cnt, c0);
    code = 10'b1100110011;
    set_exp();
    pulse_en();
    wait_cko(200);
    tick(3);
    check("restart_cko", cko_cnt, c0 + 1);
    check("restart_data", 32'(bus.DATA), 32'h333);

    // RDY withheld on bit 0
    code = 10'b1111100000;
    badm = '0;
    dly  = 0;
    withhold = 1'b1;
`ifdef SAR_CMP_TMO_EN
    exp_data    = code;
    exp_data[0] = 1'b0;
    exp_err     = 1'b1;
    pulse_en();
    wait_cko(200);
    tick(3);
    check("tmo_data", 32'(bus.DATA), 32'h1E0);
    check("tmo_err", {31'b0, bus.ERR}, 32'd1);
    withhold = 1'b0;
`else
    set_exp();
    c0 = cko_cnt;
    pulse_en();
    tick(60);
    check("stall_no_cko", cko_cnt, c0);
    check("stall_cmp_en", {31'b0, bus.CMP_EN}, 32'd1);
    withhold = 1'b0;
    wait_cko(200);
    tick(3);
    check("stall_data", 32'(bus.DATA), 32'h3E0);
    check("stall_err", {31'b0, bus.ERR}, 32'd0);
`endif

    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
